// File: rtl/vga_sync.sv
// ============================================================================
// vga_sync : pixel-clock prescaler and VGA raster timing generator
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_sync #(
  parameter int CLK_DIV = 2,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] C_DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [9:0]    C_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    C_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    C_H_DISP   = 10'(H_DISP);
  localparam logic [9:0]    C_V_DISP   = 10'(V_DISP);
  localparam logic [9:0]    C_HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0]    C_HS_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0]    C_VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0]    C_VS_END   = 10'(V_DISP + V_FP + V_SYNC);

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    pixel_x_q, pixel_x_d;
  logic [9:0]    pixel_y_q, pixel_y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          frame_tick_q, frame_tick_d;
  logic          pix_adv;

  assign pix_adv = (presc_q == C_DIV_LAST);

  // Undivided clock: the strobe follows reset directly so it is high from release on.
  generate
    if (CLK_DIV == 1) begin : g_div1
      assign p_tick = rstn;
    end else begin : g_divn
      assign p_tick = pix_adv;
    end
  endgenerate

  always_comb begin
    presc_d      = pix_adv ? '0 : presc_q + PW'(1);
    pixel_x_d    = pixel_x_q;
    pixel_y_d    = pixel_y_q;
    frame_tick_d = 1'b0;
    if (pix_adv) begin
      if (pixel_x_q == C_H_LAST) begin
        pixel_x_d = '0;
        if (pixel_y_q == C_V_LAST) begin
          pixel_y_d    = '0;
          frame_tick_d = 1'b1;
        end else begin
          pixel_y_d = pixel_y_q + 10'd1;
        end
      end else begin
        pixel_x_d = pixel_x_q + 10'd1;
      end
    end
    // Decoded from the next position so the flags line up with the counters.
    hsync_d    = !((pixel_x_d >= C_HS_START) && (pixel_x_d < C_HS_END));
    vsync_d    = !((pixel_y_d >= C_VS_START) && (pixel_y_d < C_VS_END));
    video_on_d = (pixel_x_d < C_H_DISP) && (pixel_y_d < C_V_DISP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q      <= '0;
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pixel_x_q    <= pixel_x_d;
      pixel_y_q    <= pixel_y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync.sv
// ============================================================================
// tb_vga_sync : scoreboard bench for vga_sync (CLK_DIV=2 and CLK_DIV=1 instances)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_PIX = HT * VT;
  localparam int REFRESH_Y = VD + 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pt;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ft;
  } exp_t;

  localparam exp_t RST_VAL = '{x: 10'd0, y: 10'd0, pt: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b1, ft: 1'b0};

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       pt_a, vo_a, hs_a, vs_a, ft_a;
  logic [9:0] x_a, y_a;
  logic       pt_b, vo_b, hs_b, vs_b, ft_b;
  logic [9:0] x_b, y_b;

  always #5 clk = ~clk;

  vga_sync #(.CLK_DIV(2), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut_a (
    .clk(clk), .rstn(rstn), .p_tick(pt_a), .pixel_x(x_a), .pixel_y(y_a),
    .video_on(vo_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a));

  vga_sync #(.CLK_DIV(1), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut_b (
    .clk(clk), .rstn(rstn), .p_tick(pt_b), .pixel_x(x_b), .pixel_y(y_b),
    .video_on(vo_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b));

  exp_t act_a, act_b;
  assign act_a = {x_a, y_a, pt_a, hs_a, vs_a, vo_a, ft_a};
  assign act_b = {x_b, y_b, pt_b, hs_b, vs_b, vo_b, ft_b};

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   episode  = -1;
  int   kidx     = 0;
  int   refresh_cnt = 0;
  int   von_clks    = 0;
  logic prev_refresh = 1'b0;

  // State seen k clock edges after reset release, from raster arithmetic alone.
  function automatic exp_t model(input int k, input int div);
    exp_t e;
    int   p, x, y;
    p     = k / div;
    x     = p % HT;
    y     = (p / HT) % VT;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.pt  = ((k + 1) % div) == 0;
    e.hs  = !(x >= HD + HF && x < HD + HF + HS);
    e.vs  = !(y >= VD + VF && y < VD + VF + VS);
    e.von = (x < HD) && (y < VD);
    e.ft  = ((k % div) == 0) && (p > 0) && ((p % FRAME_PIX) == 0);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t act, input exp_t exp, input int k);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d act x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b req x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b",
               nm, k, act.x, act.y, act.pt, act.hs, act.vs, act.von, act.ft,
               exp.x, exp.y, exp.pt, exp.hs, exp.vs, exp.von, exp.ft);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s act=%0d req=%0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expected entry per DUT for every clock while running.
  always @(negedge clk) begin
    exp_t e;
    logic is_ref;
    if (!rstn) begin
      cmp("reset_hold_a", act_a, RST_VAL, -1);
      cmp("reset_hold_b", act_b, RST_VAL, -1);
      kidx = 0;
      prev_refresh = 1'b0;
    end else begin
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        cmp("sb_div2", act_a, e, kidx);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        cmp("sb_div1", act_b, e, kidx);
      end
      kidx++;
      if (episode == 0) begin
        is_ref = (x_a == 10'd0) && (y_a == 10'(REFRESH_Y));
        if (is_ref && !prev_refresh) refresh_cnt++;
        prev_refresh = is_ref;
        if (vo_a) von_clks++;
      end
    end
  end

  task automatic run_episode(input int len, input int epi);
    for (int k = 0; k < len; k++) begin
      q_a.push_back(model(k, 2));
      q_b.push_back(model(k, 1));
    end
    episode = epi;
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (len) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    cmp("async_reset_a", act_a, RST_VAL, len);
    cmp("async_reset_b", act_b, RST_VAL, len);
    cmp_int("queue_drained", q_a.size() + q_b.size(), 0);
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    // Exactly three frames of the divided instance.
    run_episode(3 * FRAME_PIX * 2, 0);
    cmp_int("refresh_per_3_frames", refresh_cnt, 3);
    cmp_int("video_on_clks_3_frames", von_clks, 3 * HD * VD * 2);
    // Reset lands while the divided instance is inside hsync and vsync.
    run_episode(2 * ((VD + VF) * HT + HD + HF + 1) + 1, 1);
    for (int i = 2; i < 8; i++) run_episode($urandom_range(5, 700), i);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The module SHALL have the following parameters; only CLK_DIV and the H_/V_ timing values are overridable.
- CLK_DIV, 2, clk cycles per pixel (>=1)
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_DISP, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
REQ-002 The module SHALL have the following ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- p_tick  out  1  pixel-enable strobe, one clk wide
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  high inside the visible area
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- frame_tick  out  1  one-clk pulse at the start of each frame
REQ-003 H_TOTAL SHALL equal H_DISP+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL SHALL equal V_DISP+V_FP+V_SYNC+V_BP (525 by default).

Function
REQ-004 A prescaler counter SHALL count 0..CLK_DIV-1 and wrap to 0.
REQ-005 p_tick SHALL be high for exactly the one clk in which the prescaler equals CLK_DIV-1.
REQ-006 With CLK_DIV=1, p_tick SHALL be constantly high once rstn is released.
REQ-007 pixel_x and pixel_y SHALL change only on clk edges where p_tick is high.
REQ-008 On such an edge, pixel_x SHALL increment, or wrap to 0 when it equals H_TOTAL-1.
REQ-009 pixel_y SHALL increment only on the edge where pixel_x wraps, and SHALL wrap to 0 when it equals V_TOTAL-1.
REQ-010 hsync, vsync, video_on and frame_tick SHALL be registered; each SHALL be computed from the next-state counter values so that it is valid in the same cycle as the pixel_x/pixel_y it describes.
REQ-011 hsync SHALL be 0 exactly when H_DISP+H_FP <= pixel_x < H_DISP+H_FP+H_SYNC (656..751 by default), and 1 otherwise.
REQ-012 vsync SHALL be 0 exactly when V_DISP+V_FP <= pixel_y < V_DISP+V_FP+V_SYNC (490..491 by default), and 1 otherwise.
REQ-013 video_on SHALL be 1 exactly when pixel_x < H_DISP and pixel_y < V_DISP.
REQ-014 frame_tick SHALL be 1 for the single clk in which pixel_x and pixel_y both become 0 from (H_TOTAL-1, V_TOTAL-1).
REQ-015 The pixel sequence within a frame SHALL contain no gaps or repeats: each (x,y) pair is held for exactly CLK_DIV clks.
REQ-016 The default frame period SHALL be 800*525*CLK_DIV clks (840000 clks at CLK_DIV=2).
REQ-017 pixel_x and pixel_y SHALL be unsigned; all comparisons SHALL be done at a width of at least 10 bits with no truncation.
REQ-018 The position (x=0, y=481), used downstream as the refresh tick, SHALL occur exactly once per frame and last one pixel period.

Reset
REQ-019 While rstn=0, asynchronously and independent of clk: prescaler=0, p_tick=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, frame_tick=0.
REQ-020 Asserting rstn in the middle of a line or frame SHALL abort the frame immediately; no partial sync pulse shall remain asserted.
REQ-021 After rstn rises, the first p_tick SHALL occur on the CLK_DIV-th clk edge, and pixel_x SHALL become 1 on that edge.
REQ-022 No frame_tick SHALL be generated by reset release itself.

Verification
REQ-023 Reset release, CLK_DIV=2 -> p_tick on edges 2, 4, 6, ...; pixel_x=1 after edge 2; hsync=1, vsync=1, video_on=1.
REQ-024 Run one line -> hsync low for exactly 96 pixel periods (192 clks) starting at pixel_x=656; video_on falls at pixel_x=640; pixel_x wraps 799->0 as pixel_y goes 0->1.
REQ-025 Run a full frame -> vsync low only for lines 490-491 (1600 pixel periods); exactly one frame_tick, 840000 clks after the previous one; pixel_y wraps 524->0.
REQ-026 Assert rstn at (x=700, y=490), i.e. during hsync and vsync -> all outputs take their reset values immediately without waiting for clk; counting resumes from (0,0).
REQ-027 CLK_DIV=1 -> p_tick constantly 1; line period 800 clks; frame period 420000 clks.
REQ-028 Scoreboard over 3 frames -> (x=0, y=481) seen exactly once per frame; video_on high for exactly 307200 pixel periods per frame.
